// File: rtl/jogador_automatico_pkg.sv
// Shared types and constants for the memory-game automatic player.
// State codes, colour one-hot values and LFSR seed/taps.
package jogador_automatico_pkg;

  typedef enum logic [2:0] {
    ST_OCIOSO     = 3'd0,
    ST_CAPTURA    = 3'd1,
    ST_VEZ        = 3'd2,
    ST_PRESS      = 3'd3,
    ST_SOLTA      = 3'd4,
    ST_FIM_RODADA = 3'd5,
    ST_NOVO       = 3'd6,
    ST_FINAL      = 3'd7
  } estado_t;

  localparam logic [3:0] COR_NENHUMA  = 4'b0000;
  localparam logic [3:0] COR_VERDE    = 4'b0001;
  localparam logic [3:0] COR_VERMELHO = 4'b0010;
  localparam logic [3:0] COR_AZUL     = 4'b0100;
  localparam logic [3:0] COR_AMARELO  = 4'b1000;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] onehot2(
    input logic [1:0] s
  );
    return COR_VERDE << s;
  endfunction

endpackage

// File: rtl/jogador_automatico_memoria.sv
// Colour store for the automatic player.
// Synchronous write, asynchronous read.
module memoria_bot #(
  parameter int PROF   = 16,
  parameter int ADDR_W = $clog2(PROF)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [3:0]        rdata
);

  logic [3:0] mem_q [PROF];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: captures the displayed colours, replays them
// on the buttons and supplies pseudo-random new colours.
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter  int PROF     = 16,
  parameter  int T_PRESS  = 8,
  parameter  int T_GAP    = 8,
  parameter  int ERRO_IDX = 0,
  localparam int ADDR_W   = $clog2(PROF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              habilitar,
  input  logic [3:0]        leds,
  input  logic              aguardando,
  input  logic              pede_novo,
  input  logic              fim,
  output logic [3:0]        botoes,
  output logic [ADDR_W:0]   n_capturados,
  output logic              erro_captura,
  output logic [2:0]        db_estado
);

  localparam int PW   = ADDR_W + 1;
  localparam int TMAX = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [ADDR_W:0] PROF_P   = PW'(PROF);
  localparam logic [ADDR_W:0] PTR_ONE  = PW'(1);
  localparam logic [TW-1:0]   T_PRESS_L = TW'(T_PRESS - 1);
  localparam logic [TW-1:0]   T_GAP_L   = TW'(T_GAP - 1);
  localparam logic [TW-1:0]   T_ONE     = TW'(1);

  estado_t           state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              erro_q, erro_d;
  logic [3:0]        leds_q, leds_d;
  logic [3:0]        botoes_q, botoes_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              novo_q, novo_d;

  logic              cap;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [3:0]        rd_word;
  logic [3:0]        press_word;
  logic [ADDR_W:0]   rd_inc;
  logic              t_zero;
  logic [TW-1:0]     t_dec;

  assign cap    = habilitar
                && (leds != COR_NENHUMA)
                && (leds_q == COR_NENHUMA);
  assign rd_inc = rd_ptr_q + PTR_ONE;
  assign t_zero = (timer_q == '0);
  assign t_dec  = t_zero ? timer_q : timer_q - T_ONE;
  assign leds_d = leds;

  // the deliberate mistake is a rotated copy of the stored colour
  assign press_word =
    ((int'(rd_ptr_q) + 1) == ERRO_IDX)
      ? {rd_word[2:0], rd_word[3]}
      : rd_word;

  memoria_bot #(
    .PROF   (PROF),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (leds),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_word)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    erro_d   = erro_q;
    timer_d  = timer_q;
    lfsr_d   = lfsr_q;
    novo_d   = novo_q;
    we       = 1'b0;
    waddr    = wr_ptr_q[ADDR_W-1:0];

    if (state_q == ST_OCIOSO) begin
      wr_ptr_d = '0;
      erro_d   = 1'b0;
    end

    if (!habilitar) begin
      state_d = ST_OCIOSO;
    end else if (fim) begin
      state_d = ST_FINAL;
    end else begin
      unique case (state_q)
        ST_OCIOSO: begin
          if (cap) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = PTR_ONE;
            state_d  = ST_CAPTURA;
          end
        end
        ST_CAPTURA: begin
          if (cap) begin
            if (wr_ptr_q == PROF_P) begin
              erro_d = 1'b1;
            end else begin
              we       = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
          end
          if (aguardando) begin
            rd_ptr_d = '0;
            state_d  = ST_VEZ;
          end
        end
        ST_VEZ: begin
          if (aguardando) begin
            timer_d = T_PRESS_L;
            state_d = ST_PRESS;
          end
        end
        ST_PRESS: begin
          timer_d = t_dec;
          if (t_zero) begin
            timer_d = T_GAP_L;
            novo_d  = 1'b0;
            state_d = ST_SOLTA;
          end
        end
        ST_SOLTA: begin
          timer_d = t_dec;
          if (t_zero) begin
            if (novo_q) begin
              state_d = ST_FIM_RODADA;
            end else begin
              rd_ptr_d = rd_inc;
              state_d  = (rd_inc == wr_ptr_q)
                       ? ST_FIM_RODADA : ST_VEZ;
            end
          end
        end
        ST_FIM_RODADA: begin
          if (pede_novo) begin
            timer_d = T_PRESS_L;
            state_d = ST_NOVO;
          end else if (cap) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = PTR_ONE;
            state_d  = ST_CAPTURA;
          end
        end
        ST_NOVO: begin
          timer_d = t_dec;
          if (t_zero) begin
            timer_d = T_GAP_L;
            lfsr_d  = lfsr_next(lfsr_q);
            novo_d  = 1'b1;
            state_d = ST_SOLTA;
          end
        end
        ST_FINAL: begin
          state_d = ST_OCIOSO;
        end
      endcase
    end
  end

  // button follows the next state so it lines up with the state register
  always_comb begin
    botoes_d = COR_NENHUMA;
    unique case (1'b1)
      (state_d == ST_PRESS): botoes_d = press_word;
      (state_d == ST_NOVO):  botoes_d = onehot2(lfsr_q[1:0]);
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_OCIOSO;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      erro_q   <= 1'b0;
      leds_q   <= COR_NENHUMA;
      botoes_q <= COR_NENHUMA;
      timer_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      novo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      erro_q   <= erro_d;
      leds_q   <= leds_d;
      botoes_q <= botoes_d;
      timer_q  <= timer_d;
      lfsr_q   <= lfsr_d;
      novo_q   <= novo_d;
    end
  end

  assign botoes       = botoes_q;
  assign n_capturados = wr_ptr_q;
  assign erro_captura = erro_q;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: three instances (default, PROF=4,
// ERRO_IDX=2) share one game-like stimulus and a press-level model.
module tb_jogador_automatico;
  import jogador_automatico_pkg::*;

  localparam int TP   = 8;
  localparam int TG   = 8;
  localparam int MAXP = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilitar;
  logic [3:0] leds;
  logic       aguardando;
  logic       pede_novo;
  logic       fim;

  logic [3:0] bt0, bt1, bt2;
  logic [4:0] nc0, nc2;
  logic [2:0] nc1;
  logic       er0, er1, er2;
  logic [2:0] db0, db1, db2;

  always #5 clock = ~clock;

  jogador_automatico dut0 (
    .clock(clock), .reset(reset), .habilitar(habilitar),
    .leds(leds), .aguardando(aguardando),
    .pede_novo(pede_novo), .fim(fim),
    .botoes(bt0), .n_capturados(nc0),
    .erro_captura(er0), .db_estado(db0)
  );

  jogador_automatico #(.PROF(4)) dut1 (
    .clock(clock), .reset(reset), .habilitar(habilitar),
    .leds(leds), .aguardando(aguardando),
    .pede_novo(pede_novo), .fim(fim),
    .botoes(bt1), .n_capturados(nc1),
    .erro_captura(er1), .db_estado(db1)
  );

  jogador_automatico #(.ERRO_IDX(2)) dut2 (
    .clock(clock), .reset(reset), .habilitar(habilitar),
    .leds(leds), .aguardando(aguardando),
    .pede_novo(pede_novo), .fim(fim),
    .botoes(bt2), .n_capturados(nc2),
    .erro_captura(er2), .db_estado(db2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input bit ok, input string name,
                       input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // press-level monitor
  bit         mon_en = 1'b0;
  logic [3:0] exp_q [3][MAXP];
  int         exp_n [3];
  logic [3:0] got   [3][MAXP];
  int         npress[3];
  logic [3:0] prev  [3];
  int         run   [3];
  int         low   [3];
  logic [3:0] mb;

  initial forever begin
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       mb = bt0;
        1:       mb = bt1;
        default: mb = bt2;
      endcase
      if (!mon_en) begin
        prev[k]   = '0;
        run[k]    = 0;
        low[k]    = 1000;
        npress[k] = 0;
      end else begin
        check($onehot0(mb), $sformatf("onehot%0d", k), int'(mb), 0);
        if (mb != 0 && prev[k] == 0) begin
          check(low[k] >= TG, $sformatf("gap%0d", k), low[k], TG);
          check(npress[k] < exp_n[k], $sformatf("count%0d", k),
                npress[k] + 1, exp_n[k]);
          if (npress[k] < exp_n[k] && npress[k] < MAXP) begin
            check(mb == exp_q[k][npress[k]],
                  $sformatf("press%0d_%0d", k, npress[k]),
                  int'(mb), int'(exp_q[k][npress[k]]));
            got[k][npress[k]] = mb;
          end
          npress[k]++;
          run[k] = 1;
        end else if (mb != 0) begin
          check(mb == prev[k], $sformatf("hold%0d", k),
                int'(mb), int'(prev[k]));
          run[k]++;
        end else if (prev[k] != 0) begin
          check(run[k] == TP, $sformatf("len%0d", k), run[k], TP);
          low[k] = 1;
        end else if (low[k] < 1000) begin
          low[k]++;
        end
        prev[k] = mb;
      end
    end
  end

  logic [7:0] m_lfsr;
  bit         m_err1;
  logic [3:0] cols [8];

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic show(input int nn);
    for (int i = 0; i < nn; i++) begin
      leds = cols[i];
      repeat ($urandom_range(2, 5)) @(negedge clock);
      leds = '0;
      repeat ($urandom_range(2, 4)) @(negedge clock);
    end
  endtask

  task automatic wait_press(input string name);
    int w;
    w = 0;
    while (bt0 == 0 && w < 100) begin
      @(negedge clock);
      w++;
    end
    check(bt0 != 0, name, w, 100);
  endtask

  task automatic run_round(input int nn);
    int         m;
    logic [3:0] c;
    logic [3:0] nv;
    mon_en = 1'b0;
    @(negedge clock);
    m  = (nn < 4) ? nn : 4;
    nv = 4'b0001 << m_lfsr[1:0];
    for (int i = 0; i < nn; i++) begin
      exp_q[0][i] = cols[i];
      c = cols[i];
      if (i == 1) c = {c[2:0], c[3]};
      exp_q[2][i] = c;
      if (i < m) exp_q[1][i] = cols[i];
    end
    exp_q[0][nn] = nv;
    exp_q[2][nn] = nv;
    exp_q[1][m]  = nv;
    exp_n[0] = nn + 1;
    exp_n[2] = nn + 1;
    exp_n[1] = m + 1;
    mon_en = 1'b1;
    show(nn);
    repeat (2) @(negedge clock);
    if (nn > 4) m_err1 = 1'b1;
    check(nc0 == nn, "ncap0", int'(nc0), nn);
    check(nc1 == m, "ncap1", int'(nc1), m);
    check(nc2 == nn, "ncap2", int'(nc2), nn);
    check(er0 == 1'b0, "erro0", int'(er0), 0);
    check(er1 == m_err1, "erro1", int'(er1), int'(m_err1));
    aguardando = 1'b1;
    repeat (nn * 20 + 10) @(negedge clock);
    aguardando = 1'b0;
    pede_novo  = 1'b1;
    @(negedge clock);
    pede_novo  = 1'b0;
    repeat (TP + TG + 10) @(negedge clock);
    for (int k = 0; k < 3; k++)
      check(npress[k] == exp_n[k], $sformatf("npress%0d", k),
            npress[k], exp_n[k]);
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  initial begin
    reset      = 1'b0;
    habilitar  = 1'b1;
    leds       = '0;
    aguardando = 1'b0;
    pede_novo  = 1'b0;
    fim        = 1'b0;
    m_lfsr     = 8'hA5;
    m_err1     = 1'b0;
    repeat (3) @(negedge clock);
    check(bt0 == 0, "rst_botoes", int'(bt0), 0);
    check(nc0 == 0, "rst_ncap", int'(nc0), 0);
    check(er0 == 0, "rst_erro", int'(er0), 0);
    check(db0 == ST_OCIOSO, "rst_estado", int'(db0), int'(ST_OCIOSO));
    reset = 1'b1;
    @(negedge clock);

    cols[0] = 4'b0001; cols[1] = 4'b0100; cols[2] = 4'b1000;
    run_round(3);
    check(got[0][1] == 4'b0100, "lit_r0_p1", int'(got[0][1]), 4);
    check(got[0][3] == 4'b0010, "lit_novo_a5", int'(got[0][3]), 2);
    check(got[2][1] == 4'b1000, "lit_rot_r0", int'(got[2][1]), 8);

    cols[0] = 4'b0010; cols[1] = 4'b0001;
    run_round(2);
    check(got[2][1] == 4'b0010, "lit_rot_r1", int'(got[2][1]), 2);
    check(got[0][2] == 4'b0100, "lit_novo_4a", int'(got[0][2]), 4);

    cols[0] = 4'b0001; cols[1] = 4'b0010; cols[2] = 4'b0100;
    cols[3] = 4'b1000; cols[4] = 4'b0001;
    run_round(5);
    check(nc1 == 3'd4, "lit_p4_ncap", int'(nc1), 4);
    check(er1 == 1'b1, "lit_p4_erro", int'(er1), 1);
    check(npress[1] == 5, "lit_p4_presses", npress[1], 5);

    for (int r = 0; r < 5; r++) begin
      int nn;
      nn = $urandom_range(1, 6);
      for (int i = 0; i < nn; i++)
        cols[i] = 4'b0001 << $urandom_range(0, 3);
      run_round(nn);
    end

    mon_en = 1'b0;
    for (int i = 0; i < 5; i++)
      cols[i] = 4'b0001 << $urandom_range(0, 3);
    show(5);
    aguardando = 1'b1;
    wait_press("fim_press_timeout");
    repeat (3) @(negedge clock);
    check(er1 == 1'b1, "fim_erro_before", int'(er1), 1);
    fim = 1'b1;
    @(negedge clock);
    check(bt0 == 0, "fim_bt0", int'(bt0), 0);
    check(bt1 == 0, "fim_bt1", int'(bt1), 0);
    check(bt2 == 0, "fim_bt2", int'(bt2), 0);
    check(db0 == ST_FINAL, "fim_estado", int'(db0), int'(ST_FINAL));
    aguardando = 1'b0;
    repeat (3) @(negedge clock);
    fim = 1'b0;
    repeat (3) @(negedge clock);
    check(db0 == ST_OCIOSO, "fim_ocioso", int'(db0), int'(ST_OCIOSO));
    check(er1 == 1'b0, "fim_erro_clr", int'(er1), 0);
    check(nc0 == 0, "fim_ncap_clr", int'(nc0), 0);

    cols[0] = 4'b0100; cols[1] = 4'b0010; cols[2] = 4'b1000;
    show(3);
    aguardando = 1'b1;
    wait_press("rst_press_timeout");
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check(bt0 == 0, "rstmid_bt0", int'(bt0), 0);
    check(bt1 == 0, "rstmid_bt1", int'(bt1), 0);
    check(bt2 == 0, "rstmid_bt2", int'(bt2), 0);
    check(db0 == ST_OCIOSO, "rstmid_estado", int'(db0), 0);
    check(nc0 == 0, "rstmid_ncap", int'(nc0), 0);
    aguardando = 1'b0;
    @(negedge clock);
    reset  = 1'b1;
    m_lfsr = 8'hA5;
    m_err1 = 1'b0;

    habilitar = 1'b0;
    show(3);
    repeat (2) @(negedge clock);
    check(nc0 == 0, "dis_ncap", int'(nc0), 0);
    check(db0 == ST_OCIOSO, "dis_estado", int'(db0), 0);
    aguardando = 1'b1;
    repeat (40) @(negedge clock);
    check(bt0 == 0, "dis_botoes", int'(bt0), 0);
    aguardando = 1'b0;
    habilitar  = 1'b1;
    @(negedge clock);

    cols[0] = 4'b1000; cols[1] = 4'b0001;
    run_round(2);
    check(got[0][2] == 4'b0010, "lit_novo_reseed", int'(got[0][2]), 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
